cp0_exception_sequencer: RTL

Multi-cycle controller that owns the single coprocessor-0 write port and sequences exception entry, ERET return and MTC0 writes onto it. Sits beside the memory access stage: takes the exception request, faulting PC and forwarded Status/Cause/EPC values from that stage, and arbitrates them against the writeback stage's MTC0 write. It drives the CP0 register-file write port, the pipeline stall and flush, and the PC redirect.

---
 rtl/cp0_exception_sequencer_if.sv | 50 +++++
 rtl/cp0_exception_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception_sequencer_if.sv
// Bundle of the request, acknowledge and CP0 write-port signals around the
// exception sequencer.
//   master: pipeline side. It drives the exception, ERET and MTC0 requests and
//           the forwarded CP0 values, and receives the accepts, the CP0 write
//           port and the pipeline control outputs.
//   slave : the sequencer, with every direction reversed.
interface cp0_exception_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  exc_req;
    logic [4:0]            exc_code;
    logic [DATA_WIDTH-1:0] exc_pc;
    logic                  exc_bd;
    logic                  eret_req;
    logic [DATA_WIDTH-1:0] cp0_status;
    logic [DATA_WIDTH-1:0] cp0_cause;
    logic [DATA_WIDTH-1:0] cp0_epc;
    logic                  mtc0_valid;
    logic [4:0]            mtc0_addr;
    logic [DATA_WIDTH-1:0] mtc0_data;
    logic                  mtc0_ready;
    logic                  exc_ack;
    logic                  eret_ack;
    logic                  cp0_we;
    logic [4:0]            cp0_waddr;
    logic [DATA_WIDTH-1:0] cp0_wdata;
    logic                  stall;
    logic                  flush;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  busy;

    modport master (
        output exc_req, exc_code, exc_pc, exc_bd, eret_req,
               cp0_status, cp0_cause, cp0_epc,
               mtc0_valid, mtc0_addr, mtc0_data,
        input  mtc0_ready, exc_ack, eret_ack,
               cp0_we, cp0_waddr, cp0_wdata,
               stall, flush, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  exc_req, exc_code, exc_pc, exc_bd, eret_req,
               cp0_status, cp0_cause, cp0_epc,
               mtc0_valid, mtc0_addr, mtc0_data,
        output mtc0_ready, exc_ack, eret_ack,
               cp0_we, cp0_waddr, cp0_wdata,
               stall, flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/cp0_exception_sequencer.sv
// Owns the single CP0 write port. It sequences exception entry
// (EPC, Cause, Status, then redirect), ERET return (Status, then redirect)
// and writeback MTC0 writes onto that port.
// Ports:
//   clk, rst : clock and synchronous active-high reset.
//   bus      : slave side of cp0_exception_sequencer_if. It carries the
//              requests and forwarded CP0 values, the combinational accepts
//              (exc_ack, eret_ack, mtc0_ready), and the registered CP0 write
//              port, stall, flush, redirect and busy.
module cp0_exception_sequencer #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = DATA_WIDTH'(32'h0000_0080)
) (
    input  logic                          clk,
    input  logic                          rst,
    cp0_exception_sequencer_if.slave      bus
);
    localparam int unsigned AW = 5;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_W_EPC    = 3'd1;
    localparam logic [2:0] S_W_CAUSE  = 3'd2;
    localparam logic [2:0] S_W_STATUS = 3'd3;
    localparam logic [2:0] S_E_STATUS = 3'd4;
    localparam logic [2:0] S_MTC0     = 3'd5;
    localparam logic [2:0] S_REDIRECT = 3'd6;

    localparam logic [AW-1:0] REG_STATUS = AW'(12);
    localparam logic [AW-1:0] REG_CAUSE  = AW'(13);
    localparam logic [AW-1:0] REG_EPC    = AW'(14);

    logic [2:0]            state_q, state_d;
    logic [4:0]            code_q, code_d;
    logic                  bd_q, bd_d;
    logic                  exl_q, exl_d;
    logic                  eret_q, eret_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] status_q, status_d;
    logic [DATA_WIDTH-1:0] cause_q, cause_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic [AW-1:0]         maddr_q, maddr_d;
    logic [DATA_WIDTH-1:0] mdata_q, mdata_d;

    logic                  cp0_we_q, cp0_we_d;
    logic [AW-1:0]         cp0_waddr_q, cp0_waddr_d;
    logic [DATA_WIDTH-1:0] cp0_wdata_q, cp0_wdata_d;
    logic                  stall_q, stall_d;
    logic                  flush_q, flush_d;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic                  busy_q, busy_d;

    logic                  idle;
    logic                  exc_acc, eret_acc, mtc0_acc;
    logic [DATA_WIDTH-1:0] epc_wr, cause_wr, status_set, status_clr;

    // Accept decode: only in IDLE, exception over ERET over MTC0.
    assign idle     = (state_q == S_IDLE);
    assign exc_acc  = idle & bus.exc_req;
    assign eret_acc = idle & bus.eret_req & ~bus.exc_req;
    assign mtc0_acc = idle & bus.mtc0_valid & ~bus.exc_req & ~bus.eret_req;

    assign bus.exc_ack    = exc_acc;
    assign bus.eret_ack   = eret_acc;
    assign bus.mtc0_ready = mtc0_acc;

    // Next state and latch capture.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        bd_d     = bd_q;
        exl_d    = exl_q;
        eret_d   = eret_q;
        pc_d     = pc_q;
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;
        case (state_q)
            S_IDLE: begin
                if (exc_acc) begin
                    code_d   = bus.exc_code;
                    bd_d     = bus.exc_bd;
                    pc_d     = bus.exc_pc;
                    status_d = bus.cp0_status;
                    cause_d  = bus.cp0_cause;
                    exl_d    = bus.cp0_status[1];
                    eret_d   = 1'b0;
                    // Already in EXL: EPC is preserved, go straight to Cause.
                    state_d  = bus.cp0_status[1] ? S_W_CAUSE : S_W_EPC;
                end else if (eret_acc) begin
                    status_d = bus.cp0_status;
                    epc_d    = bus.cp0_epc;
                    eret_d   = 1'b1;
                    state_d  = S_E_STATUS;
                end else if (mtc0_acc) begin
                    maddr_d  = bus.mtc0_addr;
                    mdata_d  = bus.mtc0_data;
                    state_d  = S_MTC0;
                end
            end
            S_W_EPC:    state_d = S_W_CAUSE;
            S_W_CAUSE:  state_d = S_W_STATUS;
            S_W_STATUS: state_d = S_REDIRECT;
            S_E_STATUS: state_d = S_REDIRECT;
            S_MTC0:     state_d = S_IDLE;
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Write data for each sequence step, built from the values being latched.
    always_comb begin
        epc_wr        = bd_d ? (pc_d - DATA_WIDTH'(4)) : pc_d;
        cause_wr      = cause_d;
        cause_wr[6:2] = code_d;
        if (!exl_d) begin
            cause_wr[31] = bd_d;
        end
        status_set    = status_d | DATA_WIDTH'(2);
        status_clr    = status_d & ~DATA_WIDTH'(2);
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        cp0_we_d         = 1'b0;
        cp0_waddr_d      = '0;
        cp0_wdata_d      = '0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        case (state_d)
            S_W_EPC: begin
                cp0_we_d    = 1'b1;
                cp0_waddr_d = REG_EPC;
                cp0_wdata_d = epc_wr;
            end
            S_W_CAUSE: begin
                cp0_we_d    = 1'b1;
                cp0_waddr_d = REG_CAUSE;
                cp0_wdata_d = cause_wr;
            end
            S_W_STATUS: begin
                cp0_we_d    = 1'b1;
                cp0_waddr_d = REG_STATUS;
                cp0_wdata_d = status_set;
            end
            S_E_STATUS: begin
                cp0_we_d    = 1'b1;
                cp0_waddr_d = REG_STATUS;
                cp0_wdata_d = status_clr;
            end
            S_MTC0: begin
                cp0_we_d    = 1'b1;
                cp0_waddr_d = maddr_d;
                cp0_wdata_d = mdata_d;
            end
            S_REDIRECT: begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = eret_d ? epc_d : EXC_VECTOR;
            end
            default: ;
        endcase
        stall_d = (state_d != S_IDLE) && (state_d != S_MTC0);
        flush_d = exc_acc | eret_acc;
        busy_d  = (state_d != S_IDLE);
    end

    // State, latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            code_q           <= '0;
            bd_q             <= 1'b0;
            exl_q            <= 1'b0;
            eret_q           <= 1'b0;
            pc_q             <= '0;
            status_q         <= '0;
            cause_q          <= '0;
            epc_q            <= '0;
            maddr_q          <= '0;
            mdata_q          <= '0;
            cp0_we_q         <= 1'b0;
            cp0_waddr_q      <= '0;
            cp0_wdata_q      <= '0;
            stall_q          <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            code_q           <= code_d;
            bd_q             <= bd_d;
            exl_q            <= exl_d;
            eret_q           <= eret_d;
            pc_q             <= pc_d;
            status_q         <= status_d;
            cause_q          <= cause_d;
            epc_q            <= epc_d;
            maddr_q          <= maddr_d;
            mdata_q          <= mdata_d;
            cp0_we_q         <= cp0_we_d;
            cp0_waddr_q      <= cp0_waddr_d;
            cp0_wdata_q      <= cp0_wdata_d;
            stall_q          <= stall_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            busy_q           <= busy_d;
        end
    end

    assign bus.cp0_we         = cp0_we_q;
    assign bus.cp0_waddr      = cp0_waddr_q;
    assign bus.cp0_wdata      = cp0_wdata_q;
    assign bus.stall          = stall_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.busy           = busy_q;
endmodule
